// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the vector memory access controller.
// The state enum and alignment mask are visible to anyone that imports this package.
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE,
    RESP,
    ERR
  } state_e;

  // Vector accesses must start on a 32-bit word boundary.
  localparam logic [1:0] MEM_ALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & MEM_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and data-memory drive bundle for mem_access_ctrl.
// The slave modport is the controller's view; master is the surrounding pipeline and memory.
interface mem_access_ctrl_if #(
  parameter int dataSize       = 32,
  parameter int addressingSize = 32,
  parameter int vecSize        = 4
);

  logic                          req_valid;
  logic                          req_ready;
  logic                          req_we;
  logic [addressingSize-1:0]     req_addr;
  logic [vecSize*dataSize-1:0]   req_wdata;
  logic [5:0]                    mode_in;

  logic                          mem_we;
  logic [addressingSize-1:0]     mem_addr;
  logic [vecSize*dataSize-1:0]   mem_wdata;
  logic [5:0]                    mem_mode;
  logic [vecSize*dataSize-1:0]   mem_rdata;

  logic                          resp_valid;
  logic                          resp_ready;
  logic [vecSize*dataSize-1:0]   resp_data;
  logic                          resp_err;
  logic                          store_done;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mode_in, mem_rdata, resp_ready,
    output req_ready, mem_we, mem_addr, mem_wdata, mem_mode, resp_valid, resp_data,
           resp_err, store_done
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mode_in, mem_rdata, resp_ready,
    input  req_ready, mem_we, mem_addr, mem_wdata, mem_mode, resp_valid, resp_data,
           resp_err, store_done
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding vector load/store controller sitting directly in front of data memory.
// Loads take three cycles to respond; stores commit in the cycle after acceptance.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int dataSize       = 32,
  parameter int addressingSize = 32,
  parameter int vecSize        = 4
) (
  input logic             clk,
  input logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam int VEC_W = vecSize * dataSize;

  state_e                    state, state_nxt;
  logic                      accept;
  logic                      bad_align;
  logic [addressingSize-1:0] addr_p0;
  logic [VEC_W-1:0]          wdata_p0;
  logic [VEC_W-1:0]          rdata_p1;
  logic [5:0]                mode_p0;

  assign accept    = bus.req_valid && (state == IDLE);
  assign bad_align = misaligned(bus.req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.mem_we     = 1'b0;
    bus.store_done = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (bad_align)        state_nxt = ERR;
          else if (bus.req_we)  state_nxt = WRITE;
          else                  state_nxt = READ;
        end
      end
      WRITE: begin
        bus.mem_we     = 1'b1;
        bus.store_done = 1'b1;
        state_nxt      = IDLE;
      end
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: request latched at acceptance, held on the memory bus until the next acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0  <= '0;
      wdata_p0 <= '0;
    end else if (accept) begin
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
    end
  end

  // p1: memory returns registered data during CAPTURE; a rejected request reports zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p1 <= '0;
    end else if (accept && bad_align) begin
      rdata_p1 <= '0;
    end else if (state == CAPTURE) begin
      rdata_p1 <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_p0 <= '0;
    else        mode_p0 <= bus.mode_in;
  end

  assign bus.mem_addr  = addr_p0;
  assign bus.mem_wdata = wdata_p0;
  assign bus.mem_mode  = mode_p0;
  assign bus.resp_data = rdata_p1;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter dataSize, default 32, bits per vector lane.
REQ-002 SHALL have parameter addressingSize, default 32, byte-address width.
REQ-003 SHALL have parameter vecSize, default 4, lanes per vector access.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports req_valid in 1 / req_ready out 1  pipeline request handshake.
REQ-007 SHALL have port req_we  in  1  1 = vector store, 0 = vector load.
REQ-008 SHALL have port req_addr  in  addressingSize  byte address of lane 0.
REQ-009 SHALL have port req_wdata  in  vecSize x dataSize  store data.
REQ-010 SHALL have port mode_in  in  6  ASIP mode word forwarded to memory.
REQ-011 SHALL have ports mem_we out 1, mem_addr out addressingSize, mem_wdata out vecSize x dataSize, mem_mode out 6  data-memory drive.
REQ-012 SHALL have port mem_rdata  in  vecSize x dataSize  registered read data from data memory.
REQ-013 SHALL have ports resp_valid out 1 / resp_ready in 1, resp_data out vecSize x dataSize, resp_err out 1  load/error response.
REQ-014 SHALL have port store_done  out  1  one-cycle pulse per committed store.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, READ, CAPTURE, RESP, ERR.
REQ-016 IDLE: req_ready=1; all other states req_ready=0.
REQ-017 Acceptance (req_valid & req_ready at edge): latch addr, we, wdata; addr[1:0]!=0 -> ERR, else we ? WRITE : READ.
REQ-018 WRITE: mem_we=1 for exactly one cycle, store_done=1 same cycle, next IDLE.
REQ-019 READ: mem_we=0, mem_addr=latched addr; next CAPTURE (memory registers data at end of READ).
REQ-020 CAPTURE: register mem_rdata into resp_data; next RESP.
REQ-021 RESP: resp_valid=1, resp_err=0; hold resp_data stable until resp_ready=1, then IDLE.
REQ-022 ERR: resp_valid=1, resp_err=1, resp_data=0; no memory access; on resp_ready -> IDLE.
REQ-023 Load latency: resp_valid high in third cycle after acceptance edge; store: store_done in first cycle after acceptance edge.
REQ-024 resp_valid, store_done, mem_we SHALL never be asserted in the same cycle.
REQ-025 mem_addr, mem_wdata SHALL hold last latched values outside WRITE/READ; mem_we=0 outside WRITE.
REQ-026 mem_mode SHALL be mode_in registered every cycle, independent of FSM state.
REQ-027 resp_ready asserted while resp_valid=0 SHALL be ignored; req_valid outside IDLE SHALL be ignored (not queued).
REQ-028 Back-to-back: acceptance possible in the IDLE cycle directly after RESP/ERR handshake or WRITE; max one request in flight.
REQ-029 Address arithmetic: no wrap checking; mem_addr passed unmodified (memory performs lane offsets).

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE and zero mem_we, mem_addr, mem_wdata, mem_mode, resp_valid, resp_data, resp_err, store_done.
REQ-031 Reset mid-operation SHALL abandon the in-flight request with no response and no further memory write; req_ready=1 in first cycle after rst_n rises.

Structure
REQ-032 State enum and MEM_ALIGN_MASK constant SHALL live in shared package mem_access_pkg.
REQ-033 Block SHALL be a single module, no sub-modules; instantiated directly upstream of data memory.

Verification
REQ-034 Store: addr=0x40, wdata={4,3,2,1} -> next cycle mem_we=1, mem_addr=0x40, store_done=1; then req_ready=1.
REQ-035 Load: addr=0x40, model returns {4,3,2,1} -> resp_valid in 3rd cycle, resp_data={4,3,2,1}, resp_err=0.
REQ-036 Backpressure: load with resp_ready=0 for 5 cycles -> resp_valid and resp_data stable all 5, req_ready=0, IDLE after handshake.
REQ-037 Misaligned: addr=0x41 load -> resp_valid, resp_err=1, resp_data=0, mem_we never 1.
REQ-038 Reset in READ: rst_n low one cycle -> all outputs zero, no resp_valid, req_ready=1 after release.
REQ-039 Mode: mode_in=6'h2A -> mem_mode=6'h2A one cycle later regardless of FSM state.
